// File: rtl/fdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fdiv_pkg
// Brief    : Shared types and control encodings for the fdiv sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package fdiv_pkg;

  // Sequencer states; IDLE is the reset/accept state.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_ITER_A = 3'd3,
    ST_ITER_B = 3'd4,
    ST_ROUND  = 3'd5,
    ST_OUT    = 3'd6
  } fdiv_state_t;

  // Datapath operation select.
  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ITER  = 2'b01;
  localparam logic [1:0] OP_ROUND = 2'b10;

  // Datapath operand mux select.
  localparam logic [1:0] RM_INIT  = 2'b00;
  localparam logic [1:0] RM_LOADB = 2'b01;
  localparam logic [1:0] RM_ITA   = 2'b10;
  localparam logic [1:0] RM_ITB   = 2'b11;

  // Control vector presented to the divider datapath each cycle.
  typedef struct packed {
    logic [1:0] op;
    logic [1:0] rm;
    logic       ena;
    logic       enb;
    logic       enc;
  } fdiv_ctl_t;

  // Moore decode: control pattern is a pure function of the state.
  function automatic fdiv_ctl_t ctl_decode(input fdiv_state_t st);
    fdiv_ctl_t c;
    c = '{op: OP_LOAD, rm: RM_INIT, ena: 1'b0, enb: 1'b0, enc: 1'b0};
    case (st)
      ST_LOAD_A: c = '{op: OP_LOAD,  rm: RM_INIT,  ena: 1'b1, enb: 1'b0, enc: 1'b0};
      ST_LOAD_B: c = '{op: OP_LOAD,  rm: RM_LOADB, ena: 1'b0, enb: 1'b1, enc: 1'b1};
      ST_ITER_A: c = '{op: OP_ITER,  rm: RM_ITA,   ena: 1'b1, enb: 1'b0, enc: 1'b0};
      ST_ITER_B: c = '{op: OP_ITER,  rm: RM_ITB,   ena: 1'b0, enb: 1'b1, enc: 1'b1};
      ST_ROUND:  c = '{op: OP_ROUND, rm: RM_LOADB, ena: 1'b0, enb: 1'b0, enc: 1'b0};
      default:   c = '{op: OP_LOAD,  rm: RM_INIT,  ena: 1'b0, enb: 1'b0, enc: 1'b0};
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fdiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : fdiv_seq
// Brief    : Load / iterate / round sequencer with iteration-pair counter.
// Revision : 1.0 - initial release
// ============================================================================
module fdiv_seq
  import fdiv_pkg::*;
#(
  parameter int ITERS = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        out_ready,
  output fdiv_state_t state,
  output fdiv_ctl_t   ctl
);

  localparam int CW = $clog2(ITERS + 1);
  // Counter value seen in the final ITER_B of a transaction.
  localparam logic [CW-1:0] CNT_LAST = CW'(ITERS - 1);

  fdiv_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // State and counter registers; low reset returns to IDLE from anywhere.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter update and Moore control decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctl     = ctl_decode(state_q);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d   = '0;
          state_d = ST_LOAD_A;
        end
      end
      ST_LOAD_A: state_d = ST_LOAD_B;
      ST_LOAD_B: state_d = ST_ITER_A;
      ST_ITER_A: state_d = ST_ITER_B;
      ST_ITER_B: begin
        // Counter tops out at ITERS, which fits CW bits, so it never wraps.
        cnt_d   = cnt_q + CW'(1);
        state_d = (cnt_q == CNT_LAST) ? ST_ROUND : ST_ITER_A;
      end
      ST_ROUND:  state_d = ST_OUT;
      ST_OUT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/fdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fdiv_ctrl
// Brief    : Handshake wrapper and operand/result registers around fdiv_seq.
// Revision : 1.0 - initial release
// ============================================================================
module fdiv_ctrl
  import fdiv_pkg::*;
#(
  parameter int ITERS = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_n,
  input  logic [31:0] in_d,
  output logic [31:0] fd_n,
  output logic [31:0] fd_d,
  output logic [1:0]  fd_op,
  output logic [1:0]  fd_rm,
  output logic        fd_ena,
  output logic        fd_enb,
  output logic        fd_enc,
  input  logic [31:0] fd_q,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_q,
  output logic        out_dz
);

  fdiv_state_t state;
  fdiv_ctl_t   ctl;
  logic        accept;

  logic [31:0] n_q, n_d;
  logic [31:0] d_q, d_d;
  logic        dz_q, dz_d;
  logic [31:0] q_q, q_d;
  logic        qdz_q, qdz_d;

  // Only IDLE accepts; accept feeds registers only, never an output directly.
  assign accept = in_valid && (state == ST_IDLE);

  fdiv_seq #(
    .ITERS(ITERS)
  ) u_seq (
    .clk       (clk),
    .reset     (reset),
    .start     (accept),
    .out_ready (out_ready),
    .state     (state),
    .ctl       (ctl)
  );

  // Operand latch on accept; result and dz flag captured at the ROUND edge.
  always_comb begin
    n_d   = n_q;
    d_d   = d_q;
    dz_d  = dz_q;
    q_d   = q_q;
    qdz_d = qdz_q;
    if (accept) begin
      n_d  = in_n;
      d_d  = in_d;
      dz_d = (in_d[30:0] == 31'd0);
    end
    if (state == ST_ROUND) begin
      q_d   = fd_q;
      qdz_d = dz_q;
    end
  end

  // Operand and result registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      n_q   <= '0;
      d_q   <= '0;
      dz_q  <= 1'b0;
      q_q   <= '0;
      qdz_q <= 1'b0;
    end else begin
      n_q   <= n_d;
      d_q   <= d_d;
      dz_q  <= dz_d;
      q_q   <= q_d;
      qdz_q <= qdz_d;
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_OUT);
  assign fd_n      = n_q;
  assign fd_d      = d_q;
  assign fd_op     = ctl.op;
  assign fd_rm     = ctl.rm;
  assign fd_ena    = ctl.ena;
  assign fd_enb    = ctl.enb;
  assign fd_enc    = ctl.enc;
  assign out_q     = q_q;
  assign out_dz    = qdz_q;

endmodule
`default_nettype wire

// File: tb/tb_fdiv_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fdiv_ctrl
// Brief    : Directed self-checking bench for fdiv_ctrl (ITERS=5 and ITERS=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fdiv_ctrl;

  localparam logic [6:0] C_LA = 7'b00_00_100;
  localparam logic [6:0] C_LB = 7'b00_01_011;
  localparam logic [6:0] C_IA = 7'b01_10_100;
  localparam logic [6:0] C_IB = 7'b01_11_011;
  localparam logic [6:0] C_RD = 7'b10_01_000;
  localparam logic [6:0] C_ID = 7'b00_00_000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, in_ready, out_valid, out_ready, out_dz;
  logic [31:0] in_n, in_d, fd_n, fd_d, fd_q, out_q;
  logic [1:0]  fd_op, fd_rm;
  logic        fd_ena, fd_enb, fd_enc;
  logic [6:0]  ctl;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, out_dz1;
  logic [31:0] in_n1, in_d1, fd_n1, fd_d1, fd_q1, out_q1;
  logic [1:0]  fd_op1, fd_rm1;
  logic        fd_ena1, fd_enb1, fd_enc1;
  logic [6:0]  ctl1;

  int tests = 0;
  int fails = 0;
  logic [31:0] rq;

  // Stand-in divider: known operand pairs yield their rounded quotient in ROUND.
  function automatic logic [31:0] fdiv_model(input logic [31:0] n, input logic [31:0] d);
    logic [63:0] key;
    key = {n, d};
    case (key)
      {32'h3FB851EC, 32'h3FA147AE}: return 32'h3F924925;
      {32'h3F800000, 32'h40000000}: return 32'h3F000000;
      {32'h40400000, 32'h3F800000}: return 32'h40400000;
      {32'h3F800000, 32'h80000000}: return 32'hFF800000;
      {32'h40800000, 32'h40000000}: return 32'h40000000;
      default:                      return 32'h7FC00000;
    endcase
  endfunction

  // Expected control pattern k cycles after the accept edge.
  function automatic logic [6:0] exp_ctl(input int k, input int iters);
    if (k == 0) return C_LA;
    if (k == 1) return C_LB;
    if (k < 2 + 2 * iters) return (k % 2 == 0) ? C_IA : C_IB;
    if (k == 2 + 2 * iters) return C_RD;
    return C_ID;
  endfunction

  assign fd_q  = (fd_op  == 2'b10) ? fdiv_model(fd_n,  fd_d)  : 32'hDEADBEEF;
  assign fd_q1 = (fd_op1 == 2'b10) ? fdiv_model(fd_n1, fd_d1) : 32'hDEADBEEF;
  assign ctl   = {fd_op,  fd_rm,  fd_ena,  fd_enb,  fd_enc};
  assign ctl1  = {fd_op1, fd_rm1, fd_ena1, fd_enb1, fd_enc1};

  fdiv_ctrl #(.ITERS(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_n(in_n), .in_d(in_d), .fd_n(fd_n), .fd_d(fd_d), .fd_op(fd_op),
    .fd_rm(fd_rm), .fd_ena(fd_ena), .fd_enb(fd_enb), .fd_enc(fd_enc),
    .fd_q(fd_q), .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_dz(out_dz)
  );

  fdiv_ctrl #(.ITERS(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_n(in_n1), .in_d(in_d1), .fd_n(fd_n1), .fd_d(fd_d1), .fd_op(fd_op1),
    .fd_rm(fd_rm1), .fd_ena(fd_ena1), .fd_enb(fd_enb1), .fd_enc(fd_enc1),
    .fd_q(fd_q1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_q(out_q1), .out_dz(out_dz1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_n = '0; in_d = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; in_n1 = '0; in_d1 = '0;
    tick(2);
    reset = 1'b1;

    // Reset state
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_q",     out_q,     0);
    chk("rst_out_dz",    out_dz,    0);
    chk("rst_ctl",       ctl,       C_ID);
    chk("rst_fd_n",      fd_n,      0);
    chk("rst_fd_d",      fd_d,      0);

    // Nominal divide: full control sequence and latency
    in_n = 32'h3FB851EC; in_d = 32'h3FA147AE; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 13; k++) begin
      chk($sformatf("nom_ctl_k%0d", k), ctl, exp_ctl(k, 5));
      chk($sformatf("nom_ov_k%0d", k), out_valid, 0);
      chk($sformatf("nom_ir_k%0d", k), in_ready, 0);
      if (k == 12) rq = fd_q;
      tick();
    end
    chk("nom_out_valid", out_valid, 1);
    chk("nom_out_q_vs_round", out_q, rq);
    chk("nom_out_q", out_q, 32'h3F924925);
    chk("nom_out_dz", out_dz, 0);
    chk("nom_ctl_out", ctl, C_ID);

    // Backpressure in OUT
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("bp_ov_%0d", i), out_valid, 1);
      chk($sformatf("bp_q_%0d", i), out_q, 32'h3F924925);
      chk($sformatf("bp_ir_%0d", i), in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_idle_ir", in_ready, 1);
    chk("bp_idle_ov", out_valid, 0);
    chk("bp_idle_q_kept", out_q, 32'h3F924925);

    // Busy rejection: new operands offered during ITER_B
    in_n = 32'h3F800000; in_d = 32'h40000000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(3);
    chk("busy_ctl_iterb", ctl, C_IB);
    in_n = 32'hC2C80000; in_d = 32'h41200000; in_valid = 1'b1;
    tick();
    chk("busy_fd_n", fd_n, 32'h3F800000);
    chk("busy_fd_d", fd_d, 32'h40000000);
    tick();
    in_valid = 1'b0;
    tick(7);
    chk("busy_round_ctl", ctl, C_RD);
    chk("busy_round_fd_n", fd_n, 32'h3F800000);
    chk("busy_round_fd_d", fd_d, 32'h40000000);
    tick();
    chk("busy_out_valid", out_valid, 1);
    chk("busy_out_q", out_q, 32'h3F000000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in ITER_A of iteration 3
    in_n = 32'h40400000; in_d = 32'h3F800000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(6);
    chk("rmid_ctl_itera", ctl, C_IA);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rmid_in_ready", in_ready, 1);
    chk("rmid_ctl", ctl, C_ID);
    chk("rmid_out_valid", out_valid, 0);
    chk("rmid_out_q", out_q, 0);
    chk("rmid_fd_n", fd_n, 0);
    tick();
    chk("rmid_still_idle", in_ready, 1);

    // Divide by zero (negative zero divisor) runs full length
    in_n = 32'h3F800000; in_d = 32'h80000000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(12);
    chk("dz_round_ctl", ctl, C_RD);
    chk("dz_ov_early", out_valid, 0);
    tick();
    chk("dz_out_valid", out_valid, 1);
    chk("dz_flag", out_dz, 1);
    chk("dz_out_q", out_q, 32'hFF800000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Back-to-back with in_valid and out_ready held high
    in_n = 32'h3F800000; in_d = 32'h40000000; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_n = 32'h40800000;
    tick(13);
    chk("b2b_ov1", out_valid, 1);
    chk("b2b_q1", out_q, 32'h3F000000);
    chk("b2b_dz_cleared", out_dz, 0);
    chk("b2b_ir_13", in_ready, 0);
    tick();
    chk("b2b_ir_14", in_ready, 1);
    chk("b2b_ov_14", out_valid, 0);
    tick();
    in_valid = 1'b0;
    chk("b2b_ctl_second", ctl, C_LA);
    chk("b2b_fd_n_second", fd_n, 32'h40800000);
    tick(13);
    chk("b2b_ov2", out_valid, 1);
    chk("b2b_q2", out_q, 32'h40000000);
    tick();
    out_ready = 1'b0;
    chk("b2b_end_idle", in_ready, 1);

    // ITERS=1 build
    in_n1 = 32'h40800000; in_d1 = 32'h40000000; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("it1_ctl_k%0d", k), ctl1, exp_ctl(k, 1));
      chk($sformatf("it1_ov_k%0d", k), out_valid1, 0);
      tick();
    end
    chk("it1_out_valid", out_valid1, 1);
    chk("it1_out_q", out_q1, 32'h40000000);
    chk("it1_in_ready", in_ready1, 0);
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    chk("it1_idle", in_ready1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
